// File: rtl/counter_pkg.sv
// Shared definitions for the countdown timer: default width and FSM encoding.
package counter_pkg;

  localparam int unsigned DefaultCw = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Load and expiry handshakes of the countdown timer.
interface countdown_timer_if
  import counter_pkg::*;
#(
  parameter int unsigned CW = DefaultCw
) ();

  logic          i_load_valid;
  logic [CW-1:0] i_load_value;
  logic          i_load_auto;
  logic          o_load_ready;
  logic          o_expire_valid;
  logic          i_expire_ready;

  // Master issues loads and consumes expiry events.
  modport master (
    output i_load_valid,
    output i_load_value,
    output i_load_auto,
    output i_expire_ready,
    input  o_load_ready,
    input  o_expire_valid
  );

  // Slave is the timer itself.
  modport slave (
    input  i_load_valid,
    input  i_load_value,
    input  i_load_auto,
    input  i_expire_ready,
    output o_load_ready,
    output o_expire_valid
  );

endinterface

// File: rtl/countdown_event_hold.sv
// Holds a pending expiry event until acknowledged and flags events lost while one is pending.
module countdown_event_hold (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic event_i,
  input  logic ready_i,
  input  logic clear_overrun_i,
  output logic valid_o,
  output logic overrun_o
);

  logic valid_q, valid_d;
  logic overrun_q, overrun_d;

  // Next pending/overrun state; a new event always wins over an acknowledge.
  always_comb begin
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (event_i) begin
      valid_d = 1'b1;
      if (valid_q && !ready_i) begin
        overrun_d = 1'b1;
      end
    end
    if (clear_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  // Registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with one-shot/auto-reload modes, pause, abort and expiry handshake.
module countdown_timer
  import counter_pkg::*;
#(
  parameter int unsigned CW = DefaultCw
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  countdown_timer_if.slave   bus_io,
  input  logic               i_pause,
  input  logic               i_abort,
  output logic [CW-1:0]      o_count,
  output logic               o_busy,
  output logic               o_overrun
);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] period_q, period_d;
  logic          auto_q, auto_d;

  logic load_accept;
  logic active;
  logic expire;

  // A HOLD cycle with pause released counts like RUN, so a pause of N cycles delays expiry by N.
  assign load_accept = bus_io.i_load_valid && (state_q == StIdle);
  assign active      = (state_q != StIdle) && !i_abort && !i_pause;
  assign expire      = active && (count_q == '0);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort beats pause beats expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_accept) begin
          state_d = StRun;
        end
      end
      StRun, StHold: begin
        if (i_abort) begin
          state_d = StIdle;
        end else if (i_pause) begin
          state_d = StHold;
        end else if (expire && !auto_q) begin
          state_d = StIdle;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs from registered state only.
  always_comb begin
    bus_io.o_load_ready = (state_q == StIdle);
    o_busy              = (state_q != StIdle);
  end

  // Next count, period and mode; count never goes below zero since expiry handles zero.
  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    auto_d   = auto_q;
    if (load_accept) begin
      count_d  = bus_io.i_load_value;
      period_d = bus_io.i_load_value;
      auto_d   = bus_io.i_load_auto;
    end else if ((state_q != StIdle) && i_abort) begin
      count_d = '0;
    end else if (expire) begin
      count_d = auto_q ? period_q : '0;
    end else if (active) begin
      count_d = count_q - CW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q  <= '0;
      period_q <= '0;
      auto_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
      auto_q   <= auto_d;
    end
  end

  assign o_count = count_q;

  countdown_event_hold u_event_hold (
    .clk_i           (i_clk),
    .rst_ni          (i_rst_n),
    .event_i         (expire),
    .ready_i         (bus_io.i_expire_ready),
    .clear_overrun_i (load_accept),
    .valid_o         (bus_io.o_expire_valid),
    .overrun_o       (o_overrun)
  );

`ifdef FORMAL
  // Count stays within the loaded period, and ready is exactly the idle indication.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && o_busy) begin
      assert (count_q <= period_q);
    end
    assert (bus_io.o_load_ready == !o_busy);
  end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table through a scoreboard plus a period check.
module tb_countdown_timer;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] count;
  logic          busy;
  logic          overrun;

  countdown_timer_if #(.CW(CW)) bus ();

  countdown_timer #(.CW(CW)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus_io    (bus),
    .i_pause   (pause),
    .i_abort   (abort),
    .o_count   (count),
    .o_busy    (busy),
    .o_overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          lv;
    logic [CW-1:0] val;
    logic          au;
    logic          pz;
    logic          ab;
    logic          rdy;
    logic [CW-1:0] e_count;
    logic          e_busy;
    logic          e_ev;
    logic          e_ov;
  } vec_t;

  typedef struct {
    logic [CW-1:0] count;
    logic          busy;
    logic          lr;
    logic          ev;
    logic          ov;
    int            idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic lv, input logic [CW-1:0] v, input logic au,
                     input logic pz, input logic ab, input logic rdy, input logic [CW-1:0] ec,
                     input logic eb, input logic ee, input logic eo);
    vec_t x;
    x = '{r, lv, v, au, pz, ab, rdy, ec, eb, ee, eo};
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [CW-1:0] act,
                     input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic apply(input vec_t x, input int idx);
    exp_t e;
    rst_n              = x.rst_n;
    bus.i_load_valid   = x.lv;
    bus.i_load_value   = x.val;
    bus.i_load_auto    = x.au;
    pause              = x.pz;
    abort              = x.ab;
    bus.i_expire_ready = x.rdy;
    e = '{x.e_count, x.e_busy, ~x.e_busy, x.e_ev, x.e_ov, idx};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("count", e.idx, count, e.count);
    chk("busy", e.idx, CW'(busy), CW'(e.busy));
    chk("load_ready", e.idx, CW'(bus.o_load_ready), CW'(e.lr));
    chk("expire_valid", e.idx, CW'(bus.o_expire_valid), CW'(e.ev));
    chk("overrun", e.idx, CW'(overrun), CW'(e.ov));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last;
    bus.i_load_valid   = 1'b0;
    bus.i_load_value   = '0;
    bus.i_load_auto    = 1'b0;
    bus.i_expire_ready = 1'b0;

    // Fields: rst, load_valid, value, auto, pause, abort, ready | count, busy, expire, overrun
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    // One-shot V=3
    add(1, 1, 3, 0, 0, 0, 1,   3, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   2, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    // Auto-reload V=2, ready tied high: event every third cycle, four periods
    add(1, 1, 2, 1, 0, 0, 1,   2, 1, 0, 0);
    for (int p = 0; p < 4; p++) begin
      add(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 2, 1, 1, 0);
    end
    add(1, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0);
    // Auto-reload V=0, ready low: overrun one cycle after first pending event
    add(1, 1, 0, 1, 0, 0, 0,   0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1);
    add(1, 0, 0, 0, 0, 0, 1,   0, 1, 1, 1);
    add(1, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1);
    // Load clears overrun; one-shot V=1 event held until acknowledged
    add(1, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    // V=5, pause for 3 cycles at count 3; load request while running is ignored
    add(1, 1, 5, 0, 0, 0, 1,   5, 1, 0, 0);
    add(1, 1, 9, 1, 0, 0, 1,   4, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   3, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1,   3, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1,   3, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1,   3, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   2, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    // V=4, abort in the zero cycle: no event; pause/abort ignored in idle
    add(1, 1, 4, 0, 0, 0, 1,   4, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   3, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   2, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 1,   0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    // Abort with pause while held
    add(1, 1, 6, 0, 0, 0, 1,   6, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1,   6, 1, 0, 0);
    add(1, 0, 0, 0, 1, 1, 1,   0, 0, 0, 0);
    // Full-scale period
    add(1, 1, 16'hFFFF, 0, 0, 0, 1, 16'hFFFF, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   16'hFFFE, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0);
    // Pause at zero suppresses the event until released
    add(1, 1, 1, 0, 0, 0, 1,   1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1,   0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    // Reset mid-run with pending event and overrun, and reset over a load
    add(1, 1, 0, 1, 0, 0, 0,   0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1);
    add(0, 1, 7, 1, 0, 1, 0,   0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 7, 1, 0, 0, 0,   0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Measure event spacing for an auto-reload period of 2, bounded wait
    rst_n              = 1'b1;
    pause              = 1'b0;
    abort              = 1'b0;
    bus.i_expire_ready = 1'b1;
    bus.i_load_valid   = 1'b1;
    bus.i_load_value   = 16'd2;
    bus.i_load_auto    = 1'b1;
    @(posedge clk);
    #1;
    bus.i_load_valid = 1'b0;
    n    = 0;
    last = -1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_expire_valid) begin
        if (last >= 0) begin
          chk("event_spacing", n, CW'(c - last), CW'(3));
        end
        last = c;
        n++;
      end
    end
    chk("event_count", 1000, CW'(n), CW'(5));
    chk("no_overrun", 1001, CW'(overrun), CW'(0));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_idle", 1002, CW'(busy), CW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001: Parameter CW, default 16, SHALL set the count/period width in bits.
REQ-002: i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: i_rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-004: i_load_valid  input  1  SHALL present a load request.
REQ-005: i_load_value  input  CW  SHALL carry the period V for the load.
REQ-006: i_load_auto  input  1  SHALL select auto-reload mode for the load.
REQ-007: o_load_ready  output  1  SHALL indicate a load can be accepted.
REQ-008: i_pause  input  1  SHALL freeze the countdown while high.
REQ-009: i_abort  input  1  SHALL cancel an active countdown.
REQ-010: o_count  output  CW  SHALL show the current remaining count.
REQ-011: o_busy  output  1  SHALL be high in RUN or HOLD.
REQ-012: o_expire_valid  output  1  SHALL indicate a pending expiry event.
REQ-013: i_expire_ready  input  1  SHALL acknowledge the pending expiry event.
REQ-014: o_overrun  output  1  SHALL be a sticky flag for a lost expiry event.

Function
REQ-015: FSM states SHALL be IDLE, RUN and HOLD.
REQ-016: o_load_ready SHALL be high only in IDLE, driven from registered state.
REQ-017: Load accept (i_load_valid & o_load_ready in cycle N) SHALL give o_count=V, state RUN, and stored period=V and stored auto=i_load_auto in cycle N+1.
REQ-018: Load accept SHALL clear o_overrun. It SHALL NOT change o_expire_valid.
REQ-019: In RUN with o_count>0 and i_pause low, o_count SHALL decrement by 1 per cycle.
REQ-020: In RUN with o_count==0 and i_pause low, an expiry event SHALL occur in that cycle.
REQ-021: On an expiry event with auto set: next o_count = stored period and state stays RUN. Period V therefore gives one event every V+1 cycles, and V=0 gives one event every cycle.
REQ-022: On an expiry event with auto clear: next state IDLE and o_count holds 0.
REQ-023: i_pause high in RUN SHALL move the block to HOLD next cycle with o_count frozen, and no expiry event SHALL occur in that cycle.
REQ-024: In HOLD, o_count SHALL stay frozen. The block SHALL return to RUN the cycle after i_pause falls.
REQ-025: i_abort in RUN or HOLD SHALL move the block to IDLE next cycle with o_count=0.
REQ-026: Abort SHALL take priority over both an expiry event and pause in the same cycle, so no event is generated.
REQ-027: i_abort and i_pause SHALL be ignored in IDLE.
REQ-028: On an expiry event, o_expire_valid SHALL be 1 in the next cycle.
REQ-029: o_expire_valid SHALL clear the cycle after (o_expire_valid & i_expire_ready), unless a new event occurs in that same cycle, in which case it stays 1.
REQ-030: If an event occurs while o_expire_valid=1 and i_expire_ready=0, o_overrun SHALL be set. The event is dropped and o_overrun holds until reset or the next load accept.
REQ-031: Decrement SHALL be CW-bit unsigned; o_count SHALL never wrap below 0.

Reset
REQ-032: While i_rst_n=0 at a clock edge, the next state SHALL be IDLE with o_count=0, o_busy=0, o_expire_valid=0, o_overrun=0, o_load_ready=1, and stored period/auto cleared.
REQ-033: Reset mid-RUN or mid-HOLD SHALL discard the countdown and any pending event, and SHALL take priority over load, abort and expiry.
REQ-034: Simulation initial values SHALL equal the reset values.

Structure
REQ-035: FSM state encodings and the default CW SHALL live in shared package counter_pkg.
REQ-036: The expiry valid/ready holding register and overrun logic SHALL be a sub-module, countdown_event_hold.
REQ-037: Under FORMAL, the block SHALL assert o_count <= stored period whenever busy, and SHALL assert o_load_ready == !o_busy.

Verification
REQ-038: V=3, auto=0, no pause -> o_count 3,2,1,0; one o_expire_valid pulse; IDLE; o_load_ready=1.
REQ-039: V=2, auto=1, i_expire_ready tied 1 -> events every 3 cycles for 4 periods; o_overrun stays 0.
REQ-040: V=0, auto=1, i_expire_ready=0 -> o_expire_valid=1 after the first event, and o_overrun=1 one cycle later.
REQ-041: V=5 with pause held 3 cycles at o_count=3 -> o_count stays 3 for 3 cycles, then resumes; expiry is delayed by exactly 3 cycles.
REQ-042: V=4 with i_abort asserted in the o_count==0 cycle -> no event; IDLE; o_count=0.
REQ-043: i_rst_n=0 mid-RUN with o_expire_valid=1 and o_overrun=1 -> next cycle all outputs at reset values.
